// File: rtl/diag_scan_sequencer.sv
// Diagonal ray scanner: reports the nearest occupied square on each enabled diagonal, one square per clock.
// Optional macro DIAG_SCAN_CAPTURE_EN adds own_color input and capture output.
module diag_scan_sequencer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] bigBoard,
  input  logic [5:0]   currentPosition,
  input  logic [3:0]   dir_mask,
`ifdef DIAG_SCAN_CAPTURE_EN
  input  logic         own_color,
  output logic [3:0]   capture,
`endif
  output logic         busy,
  output logic         done,
  output logic [3:0]   near_found,
  output logic [23:0]  near_pos,
  output logic [11:0]  near_piece,
  output logic [11:0]  reach
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_NEXT, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [255:0]   board_q, board_d;
  logic [5:0]     org_q, org_d;
  logic [3:0]     mask_q, mask_d;
  logic [1:0]     dir_q, dir_d;
  logic [2:0]     row_q, row_d, col_q, col_d, rem_q, rem_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [3:0]     found_q, found_d;
  logic [23:0]    pos_q, pos_d;
  logic [11:0]    piece_q, piece_d, reach_q, reach_d;
`ifdef DIAG_SCAN_CAPTURE_EN
  logic           own_q, own_d;
  logic [3:0]     capture_q, capture_d;
`endif

  logic [2:0]     nxt_row, nxt_col, sq_type;
  logic [5:0]     sq_idx;
  logic [1:0]     load_dir, next_dir;

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  // Squares available before the board edge, from 3-bit row/col fields only.
  function automatic logic [2:0] edge_dist(input logic [1:0] d, input logic [2:0] r,
                                           input logic [2:0] c);
    logic [2:0] rd, cd;
    rd = d[1] ? (3'd7 - r) : r;
    cd = d[0] ? (3'd7 - c) : c;
    return min3(rd, cd);
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign nxt_row  = dir_q[1] ? (row_q + 3'd1) : (row_q - 3'd1);
  assign nxt_col  = dir_q[0] ? (col_q + 3'd1) : (col_q - 3'd1);
  assign sq_idx   = {nxt_row, nxt_col};
  assign sq_type  = board_q[{sq_idx, 2'b00} +: 3];
  assign load_dir = lowest(dir_mask);
  assign next_dir = lowest(mask_q);

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    org_d   = org_q;
    mask_d  = mask_q;
    dir_d   = dir_q;
    row_d   = row_q;
    col_d   = col_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    found_d = found_q;
    pos_d   = pos_q;
    piece_d = piece_q;
    reach_d = reach_q;
`ifdef DIAG_SCAN_CAPTURE_EN
    own_d     = own_q;
    capture_d = capture_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        board_d = bigBoard;
        org_d   = currentPosition;
        found_d = '0;
        pos_d   = '0;
        piece_d = '0;
        reach_d = '0;
`ifdef DIAG_SCAN_CAPTURE_EN
        own_d     = own_color;
        capture_d = '0;
`endif
        if (dir_mask == 4'd0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_SCAN;
          dir_d   = load_dir;
          mask_d  = dir_mask & ~(4'b0001 << load_dir);
          row_d   = currentPosition[5:3];
          col_d   = currentPosition[2:0];
          rem_d   = edge_dist(load_dir, currentPosition[5:3], currentPosition[2:0]);
        end
      end
      S_SCAN: begin
        if (rem_q == 3'd0) begin
          state_d = S_NEXT;
        end else if (sq_type != 3'd0) begin
          state_d                 = S_NEXT;
          found_d[dir_q]          = 1'b1;
          pos_d[6*dir_q +: 6]     = sq_idx;
          piece_d[3*dir_q +: 3]   = sq_type;
`ifdef DIAG_SCAN_CAPTURE_EN
          capture_d[dir_q] = board_q[{sq_idx, 2'b11}] != own_q;
`endif
        end else begin
          // Leaving on the last in-range empty square keeps SCAN cycles equal to squares examined.
          reach_d[3*dir_q +: 3] = reach_q[3*dir_q +: 3] + 3'd1;
          row_d = nxt_row;
          col_d = nxt_col;
          rem_d = rem_q - 3'd1;
          if (rem_q == 3'd1) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (mask_q != 4'd0) begin
          state_d = S_SCAN;
          dir_d   = next_dir;
          mask_d  = mask_q & ~(4'b0001 << next_dir);
          row_d   = org_q[5:3];
          col_d   = org_q[2:0];
          rem_d   = edge_dist(next_dir, org_q[5:3], org_q[2:0]);
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      board_q <= '0;
      org_q   <= '0;
      mask_q  <= '0;
      dir_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= '0;
      pos_q   <= '0;
      piece_q <= '0;
      reach_q <= '0;
`ifdef DIAG_SCAN_CAPTURE_EN
      own_q     <= 1'b0;
      capture_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      org_q   <= org_d;
      mask_q  <= mask_d;
      dir_q   <= dir_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      pos_q   <= pos_d;
      piece_q <= piece_d;
      reach_q <= reach_d;
`ifdef DIAG_SCAN_CAPTURE_EN
      own_q     <= own_d;
      capture_q <= capture_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign near_found = found_q;
  assign near_pos   = pos_q;
  assign near_piece = piece_q;
  assign reach      = reach_q;
`ifdef DIAG_SCAN_CAPTURE_EN
  assign capture    = capture_q;
`endif

endmodule

// File: tb/tb_diag_scan_sequencer.sv
// Table-driven, scoreboarded bench for diag_scan_sequencer; honours DIAG_SCAN_CAPTURE_EN.
module tb_diag_scan_sequencer;

  typedef struct {
    logic [255:0] board;
    logic [5:0]   pos;
    logic [3:0]   mask;
    logic         own;
    logic [3:0]   found;
    logic [23:0]  npos;
    logic [11:0]  piece;
    logic [11:0]  reach;
    logic [3:0]   cap;
    int unsigned  lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] bigBoard;
  logic [5:0]   currentPosition;
  logic [3:0]   dir_mask;
  logic         own_color;
  logic         busy, done;
  logic [3:0]   near_found;
  logic [23:0]  near_pos;
  logic [11:0]  near_piece, reach;
`ifdef DIAG_SCAN_CAPTURE_EN
  logic [3:0]   capture;
`endif

  int   checks = 0;
  int   failures = 0;
  vec_t vecs[9];
  vec_t sb[$];

  always #5 clk = ~clk;

  diag_scan_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bigBoard(bigBoard),
    .currentPosition(currentPosition), .dir_mask(dir_mask),
`ifdef DIAG_SCAN_CAPTURE_EN
    .own_color(own_color), .capture(capture),
`endif
    .busy(busy), .done(done), .near_found(near_found), .near_pos(near_pos),
    .near_piece(near_piece), .reach(reach)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] b, input int unsigned sq,
                                       input logic [3:0] v);
    b[4*sq +: 4] = v;
    return b;
  endfunction

  function automatic vec_t mk(input logic [255:0] b, input logic [5:0] p, input logic [3:0] m,
                              input logic o, input logic [3:0] f, input logic [23:0] np,
                              input logic [11:0] pc, input logic [11:0] r, input logic [3:0] c,
                              input int unsigned l);
    vec_t v;
    v.board = b; v.pos = p; v.mask = m; v.own = o; v.found = f; v.npos = np;
    v.piece = pc; v.reach = r; v.cap = c; v.lat = l;
    return v;
  endfunction

  task automatic check_results(input string tag, input vec_t e);
    chk({tag, ".found"}, 32'(near_found), 32'(e.found));
    chk({tag, ".pos"},   32'(near_pos),   32'(e.npos));
    chk({tag, ".piece"}, 32'(near_piece), 32'(e.piece));
    chk({tag, ".reach"}, 32'(reach),      32'(e.reach));
`ifdef DIAG_SCAN_CAPTURE_EN
    chk({tag, ".capture"}, 32'(capture), 32'(e.cap));
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".found"}, 32'(near_found), 0);
    chk({tag, ".pos"}, 32'(near_pos), 0);
    chk({tag, ".piece"}, 32'(near_piece), 0);
    chk({tag, ".reach"}, 32'(reach), 0);
`ifdef DIAG_SCAN_CAPTURE_EN
    chk({tag, ".capture"}, 32'(capture), 0);
`endif
  endtask

  task automatic scramble();
    bigBoard        = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
    currentPosition = 6'($urandom);
    dir_mask        = 4'($urandom);
    own_color       = 1'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned c;
    bit got;
    vec_t e;
    @(negedge clk);
    bigBoard = v.board; currentPosition = v.pos; dir_mask = v.mask; own_color = v.own;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(v);
    c = 1;
    chk({tag, ".busy_load"}, 32'(busy), 1);
    got = 0;
    while (!got && c < 200) begin
      @(posedge clk); #1;
      c++;
      if (c == 2) scramble();  // board/position are latched by now
      if (done) got = 1;
    end
    if (!got) begin
      chk({tag, ".timeout"}, 0, 1);
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk({tag, ".sb_empty_at_done"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".latency"}, c, e.lat);
      chk({tag, ".busy_done"}, 32'(busy), 0);
      check_results(tag, e);
      @(posedge clk); #1;
      chk({tag, ".done_pulse"}, 32'(done), 0);
      check_results({tag, ".hold"}, e);
    end
  endtask

  initial begin
    logic [255:0] b2;
    int unsigned rpts[2];
    int unsigned dcount;
    rst_n = 1'b0; start = 1'b0; bigBoard = '0; currentPosition = '0; dir_mask = '0;
    own_color = 1'b0;

    b2 = put(put('0, 41, 4'hD), 54, 4'h2);
    vecs[0] = mk('0, 6'd0, 4'hF, 1'b0, 4'h0, 24'd0, 12'd0, 12'hE00, 4'h0, 16);
    vecs[1] = mk(put('0, 18, 4'hB), 6'd27, 4'h1, 1'b0, 4'h1, 24'd18, 12'd3, 12'd0, 4'h1, 4);
    vecs[2] = mk(b2, 6'd27, 4'h8, 1'b0, 4'h8, 24'd54 << 18, 12'd2 << 9, 12'd2 << 9, 4'h0, 6);
    vecs[3] = mk(b2, 6'd27, 4'h0, 1'b0, 4'h0, 24'd0, 12'd0, 12'd0, 4'h0, 2);
    vecs[4] = mk(b2, 6'd27, 4'hF, 1'b0, 4'hC, (24'd54 << 18) | (24'd41 << 12),
                 (12'd2 << 9) | (12'd5 << 6), (12'd2 << 9) | (12'd1 << 6) | (12'd3 << 3) | 12'd3,
                 4'h4, 17);
    vecs[5] = mk(put('0, 0, 4'h7), 6'd63, 4'h1, 1'b1, 4'h1, 24'd0, 12'd7, 12'd6, 4'h1, 10);
    vecs[6] = mk('0, 6'd7, 4'hF, 1'b0, 4'h0, 24'd0, 12'd0, 12'd7 << 6, 4'h0, 16);
    vecs[7] = mk(put(put('0, 1, 4'h4), 7, 4'h6), 6'd8, 4'h3, 1'b0, 4'h2, 24'd1 << 6,
                 12'd4 << 3, 12'd0, 4'h0, 6);
    vecs[8] = mk(put('0, 18, 4'h3), 6'd27, 4'h1, 1'b0, 4'h1, 24'd18, 12'd3, 12'd0, 4'h0, 4);

    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start held high through the DONE cycle must not launch a second scan
    @(negedge clk);
    bigBoard = '0; currentPosition = 6'd0; dir_mask = 4'h0; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("dq.done", 32'(done), 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("dq.busy_after_done", 32'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("dq.idle%0d", k), 32'(busy | done), 0);
    end

    rpts[0] = 4; rpts[1] = 12;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      bigBoard = '0; currentPosition = 6'd0; dir_mask = 4'hF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int unsigned c = 1; c < rpts[r]; c++) begin
        @(posedge clk); #1;
      end
      chk($sformatf("rst%0d.busy_pre", r), 32'(busy), 1);
      if (rpts[r] == 12) chk("rst1.reach_pre", 32'(reach), 32'(12'd4 << 9));
      rst_n = 1'b0;
      #1 check_zero($sformatf("rst%0d.async", r));
      @(negedge clk) rst_n = 1'b1;
      dcount = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (done) dcount++;
      end
      chk($sformatf("rst%0d.no_done", r), dcount, 0);
      check_zero($sformatf("rst%0d.after", r));
      run_vec(vecs[0], $sformatf("rst%0d.fresh", r));
    end

    chk("sb.drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
